// File: rtl/rvvi_retire_tracer.sv
// rvvi_retire_tracer: producer side of an RVVI verilog-style trace port for a
// single-hart, single-issue core. Retirement events from the commit stage are
// queued in a 2-entry FIFO, then presented one per cycle on the RVVI signal
// set, with a shadow copy of the X register file kept alongside.
//
// Handshake: an event transfers on a rising edge where in_valid && in_ready.
// While in_ready is low the producer holds the event stable. The consumer
// side has no ready; out_stall=1 means the current output (valid=1) has not
// been taken, so every output holds until out_stall drops.
module rvvi_retire_tracer #(
  parameter int ILEN = 32,
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ILEN-1:0]      in_insn,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [XLEN-1:0]      in_pc_next,
  input  logic                 in_trap,
  input  logic                 in_halt,
  input  logic [1:0]           in_mode,
  input  logic                 in_rd_we,
  input  logic [4:0]           in_rd,
  input  logic [XLEN-1:0]      in_rd_wdata,
  input  logic                 out_stall,
  output logic                 valid,
  output logic [63:0]          order,
  output logic [ILEN-1:0]      insn,
  output logic                 trap,
  output logic                 halt,
  output logic [1:0]           mode,
  output logic [1:0]           ixl,
  output logic [XLEN-1:0]      pc_rdata,
  output logic [XLEN-1:0]      pc_wdata,
  output logic [32*XLEN-1:0]   x_wdata,
  output logic [31:0]          x_wb
);

  typedef struct packed {
    logic [ILEN-1:0] insn;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic            trap;
    logic            halt;
    logic [1:0]      mode;
    logic            rd_we;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd_wdata;
  } entry_t;

  // FIFO storage and pointers
  entry_t      mem_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  cnt_q, cnt_d;
  logic        halted_q;

  // Output stage registers
  logic            valid_q;
  logic [63:0]     order_q;
  logic [ILEN-1:0] insn_q;
  logic            trap_q;
  logic            halt_q;
  logic [1:0]      mode_q;
  logic [XLEN-1:0] pc_rdata_q;
  logic [XLEN-1:0] pc_wdata_q;
  logic [31:0]     x_wb_q, x_wb_d;
  logic [XLEN-1:0] xreg_q [1:31];

  entry_t in_entry, head;
  logic   fifo_empty, fifo_full, push, pop, consumed, wb_en;

  assign in_entry   = {in_insn, in_pc, in_pc_next, in_trap, in_halt, in_mode,
                       in_rd_we, in_rd, in_rd_wdata};
  assign head       = mem_q[rd_ptr_q];
  assign fifo_empty = (cnt_q == 2'd0);
  assign fifo_full  = (cnt_q == 2'd2);

  // The output register is free when empty or when its value is being taken.
  assign consumed = !valid_q || !out_stall;
  assign pop      = !fifo_empty && consumed;

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  // in_ready is forced low while reset is asserted.
  assign in_ready = rst_n && !halted_q && (!fifo_full || pop);
  assign push     = in_valid && in_ready;

  // Next occupancy and the register-writeback decision for the head entry
  always_comb begin
    cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
    wb_en  = head.rd_we && !head.trap && (head.rd != 5'd0);
    x_wb_d = '0;
    if (wb_en) x_wb_d = 32'd1 << head.rd;
  end

  // FIFO payload storage; contents are only meaningful below cnt_q
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_entry;
  end

  // FIFO pointers, occupancy and the sticky halt latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      halted_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_d;
      if (pop && head.halt) halted_q <= 1'b1;
    end
  end

  // Output stage: load the FIFO head, or drop valid once consumed, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      order_q    <= '0;
      insn_q     <= '0;
      trap_q     <= 1'b0;
      halt_q     <= 1'b0;
      mode_q     <= 2'b00;
      pc_rdata_q <= '0;
      pc_wdata_q <= '0;
      x_wb_q     <= '0;
    end else if (pop) begin
      valid_q    <= 1'b1;
      order_q    <= order_q + 64'd1;
      insn_q     <= head.insn;
      trap_q     <= head.trap;
      halt_q     <= head.halt;
      mode_q     <= head.mode;
      pc_rdata_q <= head.pc;
      pc_wdata_q <= head.pc_next;
      x_wb_q     <= x_wb_d;
    end else if (consumed) begin
      valid_q <= 1'b0;
      x_wb_q  <= '0;
    end
  end

  // Shadow register file; x0 is not stored and always reads zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) xreg_q[i] <= '0;
    end else if (pop && wb_en) begin
      xreg_q[head.rd] <= head.rd_wdata;
    end
  end

  assign x_wdata[XLEN-1:0] = '0;
  for (genvar g = 1; g < 32; g++) begin : g_xw
    assign x_wdata[g*XLEN +: XLEN] = xreg_q[g];
  end

  assign valid    = valid_q;
  assign order    = order_q;
  assign insn     = insn_q;
  assign trap     = trap_q;
  assign halt     = halt_q;
  assign mode     = mode_q;
  assign pc_rdata = pc_rdata_q;
  assign pc_wdata = pc_wdata_q;
  assign x_wb     = x_wb_q;
  assign ixl      = (XLEN == 64) ? 2'b10 : 2'b01;

endmodule
